// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Multi-cycle RV32M multiply unit (MUL / MULH / MULHSU / MULHU) that sits
//   beside the ALU in the EX stage. It is a radix-2 shift-add engine. The
//   accumulate adder is a ripple chain of full_adder cells. Sign handling is
//   done by multiplying magnitudes and negating the full 2*XLEN-bit product
//   at the end.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous, active-low reset
//   start   in   1     request; accepted only when busy=0 and flush=0
//   op      in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (sampled with start)
//   rs1     in   XLEN  multiplicand (sampled with start)
//   rs2     in   XLEN  multiplier   (sampled with start)
//   flush   in   1     synchronous abort of an operation in flight
//   busy    out  1     high while the FSM is not IDLE
//   done    out  1     one-cycle pulse; result is valid in this cycle
//   result  out  XLEN  low half (MUL) or high half (others) of the product
// ---------------------------------------------------------------------------

// Single-bit full adder cell used to build the accumulate ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg,   state_next;
  logic [CNT_W-1:0]    counter_reg, counter_next;
  logic [2*XLEN-1:0]   product_reg, product_next;
  logic [XLEN-1:0]     mcand_reg,   mcand_next;   // |rs1|
  logic                neg_reg,     neg_next;     // final product must be negated
  logic                low_reg,     low_next;     // MUL: return the low half
  logic [XLEN-1:0]     result_reg,  result_next;
  logic                done_reg,    done_next;

  // -------------------------------------------------------------------------
  // Operand conditioning (only used at the accepting edge)
  // -------------------------------------------------------------------------
  logic            rs1_signed;
  logic            rs2_signed;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;

  assign rs1_signed = (op == 2'b01) || (op == 2'b10);
  assign rs2_signed = (op == 2'b01);
  assign rs1_neg    = rs1_signed & rs1[XLEN-1];
  assign rs2_neg    = rs2_signed & rs2[XLEN-1];
  // The most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude, so no extra width is needed.
  assign rs1_mag    = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
  assign rs2_mag    = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;

  // -------------------------------------------------------------------------
  // Accumulate adder: {0, product_hi} + {0, mcand}, XLEN+1 bits wide.
  // Both top operand bits are zero, so the (XLEN+1)th sum bit is simply the
  // carry out of the last cell.
  // -------------------------------------------------------------------------
  logic [XLEN:0]   carry;
  logic [XLEN-1:0] sum_bits;
  logic [XLEN:0]   add_sum;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ripple
      full_adder u_fa (
        .a    (product_reg[XLEN+gi]),
        .b    (mcand_reg[gi]),
        .cin  (carry[gi]),
        .sum  (sum_bits[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign add_sum = {carry[XLEN], sum_bits};

  // One shift-add step: conditionally accumulate, then shift {carry, product}
  // right by one so the carry lands in the product MSB.
  logic [XLEN:0]     upper;
  logic [2*XLEN-1:0] product_step;

  assign upper        = product_reg[0] ? add_sum : {1'b0, product_reg[2*XLEN-1:XLEN]};
  assign product_step = {upper, product_reg[XLEN-1:1]};

  // Signed fix-up of the finished product, modulo 2^(2*XLEN).
  logic [2*XLEN-1:0] product_final;

  assign product_final = neg_reg ? (~product_reg + (2*XLEN)'(1)) : product_reg;

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    product_next = product_reg;
    mcand_next   = mcand_reg;
    neg_next     = neg_reg;
    low_next     = low_reg;
    result_next  = result_reg;
    done_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // flush in IDLE suppresses a simultaneous start
        if (start && !flush) begin
          mcand_next   = rs1_mag;
          neg_next     = rs1_neg ^ rs2_neg;
          low_next     = (op == 2'b00);
          product_next = {{XLEN{1'b0}}, rs2_mag};
          counter_next = '0;
          state_next   = CALC;
        end
      end

      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (counter_reg == CNT_W'(XLEN)) begin
          // All XLEN iterations are in the product register; publish the
          // selected half on the way into DONE.
          state_next  = DONE;
          done_next   = 1'b1;
          result_next = low_reg ? product_final[XLEN-1:0]
                                : product_final[2*XLEN-1:XLEN];
        end else begin
          product_next = product_step;
          counter_next = counter_reg + CNT_W'(1);
        end
      end

      DONE: begin
        // DONE always lasts exactly one cycle; start here is ignored.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      product_reg <= '0;
      mcand_reg   <= '0;
      neg_reg     <= 1'b0;
      low_reg     <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      product_reg <= product_next;
      mcand_reg   <= mcand_next;
      neg_reg     <= neg_next;
      low_reg     <= low_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
    end
  end

  // Outputs come straight from registers (busy is a decode of the state
  // register only), so there is no input-to-output combinational path.
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed self-checking bench for seq_multiplier. Each comparison is an
//   immediate assertion; one line is printed per transaction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors;
  int miscompares;

  seq_multiplier #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check latency, busy span,
  // result and that done drops after a single cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);          // accepting edge E0
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) busy_cnt++;
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    check({tag, "_latency"},   n,             32'd34);
    check({tag, "_busy_span"}, busy_cnt,      32'd34);
    check({tag, "_result"},    result,        exp_res);
    $display("op=%0d rs1=0x%08h rs2=0x%08h -> result=0x%08h cycles=%0d (%s)",
             o, a, b, result, n, tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"},  {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic [31:0] got;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    rs1   = '0;
    rs2   = '0;
    flush = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    $display("reset: busy=%0b done=%0b result=0x%08h", busy, done, result);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic products and sign combinations
    do_op(2'b00, 32'd7,        32'd6,        32'h0000002A, "mul_7x6");
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff");
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_ff");
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ff");
    do_op(2'b10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu_m1x2");
    do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    do_op(2'b01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, "mulh_m2x3");
    do_op(2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, "mul_m2x3");
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min");
    do_op(2'b11, 32'h80000000, 32'd2,        32'h00000001, "mulhu_2p32");

    // start while busy is ignored: MUL 3*5, second start at cycle 10
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    got = '0;
    for (int n = 1; n <= 60; n++) begin
      if (done === 1'b1) begin
        done_cnt++;
        got = result;
      end
      if (n == 10) begin
        start = 1'b1; rs1 = 32'd9; rs2 = 32'd9;
      end
      if (n == 11) start = 1'b0;
      @(negedge clk);
    end
    check("busy_start_done_count", done_cnt,      32'd1);
    check("busy_start_result",     got,           32'h0000000F);
    check("busy_start_idle",       {31'b0, busy}, 32'd0);
    $display("start-while-busy: dones=%0d result=0x%08h", done_cnt, got);

    // flush mid-CALC: busy drops next cycle, no done, result unchanged
    start = 1'b1; op = 2'b00; rs1 = 32'd4; rs2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 50; n++) begin
      if (done === 1'b1) done_cnt++;
      if (n == 12) flush = 1'b1;
      if (n == 13) begin
        flush = 1'b0;
        check("flush_busy_next", {31'b0, busy}, 32'd0);
      end
      @(negedge clk);
    end
    check("flush_no_done",     done_cnt, 32'd0);
    check("flush_result_kept", result,   32'h0000000F);
    $display("flush: dones=%0d result=0x%08h", done_cnt, result);
    do_op(2'b00, 32'd2, 32'd3, 32'h00000006, "restart_2x3");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'b0, busy}, 32'd0);
    check("async_rst_done",   {31'b0, done}, 32'd0);
    check("async_rst_result", result,        32'd0);
    $display("async reset: busy=%0b done=%0b result=0x%08h", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 32'd0, 32'h12345678, 32'h00000000, "mul_0_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
